// File: rtl/fpga_spi_reg_slave_if.sv
// SPI pin bundle between the NIOS SPI master (one chip select) and the register slave.
// Ports: sclk, ss_n, mosi driven by the master; miso and miso_oe driven by the slave.
// miso is only meaningful while miso_oe is high; the top level builds the tristate from it.
interface fpga_spi_reg_slave_if;
    logic sclk;
    logic ss_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output sclk,
        output ss_n,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  sclk,
        input  ss_n,
        input  mosi,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/fpga_spi_reg_slave.sv
// SPI slave register bank: 32-bit frames {W, A[14:0], D[15:0]} become 16-bit register reads/writes.
// Latency: all pins pass 2-FF synchronizers; writes commit (wr_stb, regs_o) one clk after the 32nd sclk rise is seen.
// Backpressure: none; the master paces the frame and clk must oversample sclk (>= 4 clk per half-period).
// Ports: clk, reset_n (async active-low), spi (slave modport), regs_o, wr_stb, wr_addr, wr_data.
module fpga_spi_reg_slave #(
    parameter int          ADDR_W    = 5,
    parameter logic [14:0] BASE_ADDR = 15'h0000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    fpga_spi_reg_slave_if.slave          spi,
    output logic [16*(2**ADDR_W)-1:0]    regs_o,
    output logic                         wr_stb,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [15:0]                  wr_data
);
    localparam int NREG = 2**ADDR_W;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t state_q, state_d;

    logic [1:0]        sclk_sync, ss_sync, mosi_sync;
    logic              sclk_d;
    logic              sclk_s, ss_s, mosi_s;
    logic              sclk_rise, sclk_fall;

    logic [5:0]        cnt_q;
    logic [14:0]       shift_q;
    logic [15:0]       shift_nxt;
    logic              hit_nxt;
    logic              cmd_w_q, cmd_hit_q;
    logic [ADDR_W-1:0] cmd_idx_q;
    logic [15:0]       tx_q;
    logic              miso_q, oe_q;
    logic [15:0]       regs_q [NREG];

    assign sclk_s    = sclk_sync[1];
    assign ss_s      = ss_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // Word as it will look after this rise; in CMD its top bit is W and the rest is A.
    assign shift_nxt = {shift_q, mosi_s};
    assign hit_nxt   = ((shift_nxt[14:0] >> ADDR_W) == (BASE_ADDR >> ADDR_W));

    assign spi.miso    = miso_q;
    assign spi.miso_oe = oe_q;

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign regs_o[16*k +: 16] = regs_q[k];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= 2'b11;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi.sclk};
            ss_sync   <= {ss_sync[0], spi.ss_n};
            mosi_sync <= {mosi_sync[0], spi.mosi};
            sclk_d    <= sclk_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Deselect wins from any state so a partial frame is simply dropped.
    always_comb begin
        state_d = state_q;
        if (ss_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = CMD;
                CMD:     if (sclk_rise && cnt_q == 6'd15) state_d = DATA;
                DATA:    if (sclk_rise && cnt_q == 6'd31) state_d = DONE;
                default: state_d = DONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            cmd_w_q   <= 1'b0;
            cmd_hit_q <= 1'b0;
            cmd_idx_q <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (ss_s || state_q == IDLE) begin
                cnt_q  <= '0;
                oe_q   <= 1'b0;
                miso_q <= 1'b0;
            end else begin
                case (state_q)
                    CMD: begin
                        if (sclk_rise) begin
                            shift_q <= shift_nxt[14:0];
                            cnt_q   <= cnt_q + 6'd1;
                            if (cnt_q == 6'd15) begin
                                cmd_w_q   <= shift_nxt[15];
                                cmd_idx_q <= shift_nxt[ADDR_W-1:0];
                                cmd_hit_q <= hit_nxt;
                                // Snapshot now: a later write in this frame must not alter read data.
                                if (!shift_nxt[15] && hit_nxt) begin
                                    tx_q <= regs_q[shift_nxt[ADDR_W-1:0]];
                                    oe_q <= 1'b1;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            shift_q <= shift_nxt[14:0];
                            cnt_q   <= cnt_q + 6'd1;
                            if (cnt_q == 6'd31) begin
                                oe_q <= 1'b0;
                                if (cmd_w_q && cmd_hit_q) begin
                                    regs_q[cmd_idx_q] <= shift_nxt;
                                    wr_stb            <= 1'b1;
                                    wr_addr           <= cmd_idx_q;
                                    wr_data           <= shift_nxt;
                                end
                            end
                        end else if (sclk_fall && oe_q) begin
                            // Master samples on the next rise, so present the next bit on each fall.
                            miso_q <= tx_q[15];
                            tx_q   <= {tx_q[14:0], 1'b0};
                        end
                    end
                    default: begin
                        oe_q <= 1'b0;
                        if (sclk_rise && cnt_q != 6'd32) cnt_q <= cnt_q + 6'd1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fpga_spi_reg_slave.sv
module tb_fpga_spi_reg_slave;
    logic         clk;
    logic         reset_n;
    logic [511:0] regs_o;
    logic         wr_stb;
    logic [4:0]   wr_addr;
    logic [15:0]  wr_data;

    int checks = 0;
    int errors = 0;
    int stb_total = 0;

    logic [15:0] model [32];
    logic [4:0]  m_addr;
    logic [15:0] m_data;

    fpga_spi_reg_slave_if spi();

    fpga_spi_reg_slave #(.ADDR_W(5), .BASE_ADDR(15'h0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .spi     (spi),
        .regs_o  (regs_o),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (wr_stb) stb_total++;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        for (int k = 0; k < 32; k++) f[16*k +: 16] = model[k];
        return f;
    endfunction

    // Master side of one select: nbits sclk pulses, optional reset pulse before bit rst_at.
    task automatic spi_frame(input logic [31:0] word, input int nbits, input int rst_at,
                             output logic [15:0] rx, output logic [31:0] oe_mask,
                             output logic oe_done);
        rx = '0;
        oe_mask = '0;
        @(negedge clk);
        spi.ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset_n = 1'b0;
                repeat (3) @(negedge clk);
                checks++;
                assert (spi.miso_oe === 1'b0 && wr_stb === 1'b0) else begin
                    errors++;
                    $error("FAIL reset_mid_frame: oe=%0b stb=%0b expected 0/0", spi.miso_oe, wr_stb);
                end
                reset_n = 1'b1;
                break;
            end
            spi.mosi = (i < 32) ? word[31-i] : 1'($urandom_range(0, 1));
            repeat (8) @(negedge clk);
            if (i < 32) begin
                oe_mask[31-i] = spi.miso_oe;
                if (i >= 16) rx[31-i] = spi.miso;
            end
            spi.sclk = 1'b1;
            repeat (8) @(negedge clk);
            spi.sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        oe_done = spi.miso_oe;
        spi.ss_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Runs one frame and checks it against the register-bank model.
    task automatic run_frame(input logic [31:0] word, input int nbits, input int rst_at);
        logic [15:0] rx, exp_rx;
        logic [31:0] oe_mask;
        logic        oe_done, w, hit, full, exp_stb;
        logic [14:0] a;
        logic [4:0]  idx;
        int          s0;
        w   = word[31];
        a   = word[30:16];
        idx = a[4:0];
        hit = (a >> 5) == 15'd0;
        full = (nbits >= 32) && (rst_at < 0);
        exp_rx = model[idx];
        exp_stb = full && w && hit;
        s0 = stb_total;
        spi_frame(word, nbits, rst_at, rx, oe_mask, oe_done);
        if (exp_stb) begin
            model[idx] = word[15:0];
            m_addr = idx;
            m_data = word[15:0];
        end
        if (rst_at >= 0 && rst_at < nbits) begin
            for (int k = 0; k < 32; k++) model[k] = '0;
            m_addr = '0;
            m_data = '0;
        end
        check("wr_stb_pulses", 512'(stb_total - s0), 512'(exp_stb));
        check("wr_addr", 512'(wr_addr), 512'(m_addr));
        check("wr_data", 512'(wr_data), 512'(m_data));
        check("regs_o", regs_o, model_flat());
        check("miso_oe_idle", 512'(spi.miso_oe), 512'(0));
        if (full) begin
            check("miso_oe_window", 512'(oe_mask), 512'((!w && hit) ? 32'h0000_FFFF : 32'h0));
            check("miso_oe_done", 512'(oe_done), 512'(0));
            if (!w && hit) check("read_data", 512'(rx), 512'(exp_rx));
        end
    endtask

    initial begin
        logic [31:0] word;
        logic [14:0] a;
        reset_n  = 1'b0;
        spi.sclk = 1'b0;
        spi.ss_n = 1'b1;
        spi.mosi = 1'b0;
        for (int k = 0; k < 32; k++) model[k] = '0;
        m_addr = '0;
        m_data = '0;
        repeat (3) @(negedge clk);
        check("reset_miso", 512'(spi.miso), 512'(0));
        check("reset_miso_oe", 512'(spi.miso_oe), 512'(0));
        check("reset_wr_stb", 512'(wr_stb), 512'(0));
        check("reset_wr_addr", 512'(wr_addr), 512'(0));
        check("reset_wr_data", 512'(wr_data), 512'(0));
        check("reset_regs", regs_o, 512'(0));
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        run_frame(32'h8003_A5C3, 32, -1);
        check("reg3_value", 512'(regs_o[63:48]), 512'(16'hA5C3));
        run_frame(32'h0003_0000, 32, -1);
        run_frame(32'h8040_1234, 32, -1);
        run_frame(32'h0040_0003, 32, -1);
        run_frame(32'h8001_00FF, 20, -1);
        run_frame(32'h8001_00FF, 32, -1);
        check("reg1_value", 512'(regs_o[31:16]), 512'(16'h00FF));
        run_frame(32'h8002_BEEF, 40, -1);
        check("reg2_value", 512'(regs_o[47:32]), 512'(16'hBEEF));
        run_frame(32'h0002_0000, 32, -1);
        run_frame(32'h8004_FFFF, 32, 24);
        check("regs_after_reset", regs_o, 512'(0));
        run_frame(32'h0003_0000, 32, -1);
        run_frame(32'h8005_1111, 32, -1);
        run_frame(32'h0005_0000, 32, -1);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) a = 15'($urandom);
            else a = {10'd0, 5'($urandom)};
            word = {1'($urandom_range(0, 1)), a, 16'($urandom)};
            run_frame(word, 32, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
